// File: rtl/minhash_sig_unit_if.sv
// Stream interface for the MinHash signature unit: shingle input side and
// signature output side, each with its own valid/ready handshake.
interface minhash_sig_unit_if #(
  parameter int DATA_BITS     = 8,
  parameter int SHINGLE_BYTES = 2,
  parameter int NUM_HASHES    = 4,
  parameter int HASH_BITS     = 16,
  parameter int MAX_SHINGLES  = 64
);
  localparam int SHINGLE_W = SHINGLE_BYTES * DATA_BITS;
  localparam int SIG_W     = NUM_HASHES * HASH_BITS;
  localparam int CNT_W     = $clog2(MAX_SHINGLES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [SHINGLE_W-1:0] in_shingle;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [SIG_W-1:0]     out_sig;
  logic [CNT_W-1:0]     out_count;

  // Producer of shingles / consumer of signatures (bench or upstream glue).
  modport master (
    output in_valid, in_shingle, in_last, out_ready,
    input  in_ready, out_valid, out_sig, out_count
  );

  // The signature unit itself.
  modport slave (
    input  in_valid, in_shingle, in_last, out_ready,
    output in_ready, out_valid, out_sig, out_count
  );
endinterface

// File: rtl/minhash_sig_unit.sv
// MinHash signature unit: hashes one shingle per cycle with NUM_HASHES affine
// hashes, tracks the per-hash minimum across a block, and hands the signature
// plus a saturating shingle count to the similarity stage on the block's end.
module minhash_sig_unit #(
  parameter int DATA_BITS     = 8,
  parameter int SHINGLE_BYTES = 2,
  parameter int NUM_HASHES    = 4,
  parameter int HASH_BITS     = 16,
  parameter int MAX_SHINGLES  = 64
) (
  input logic              clk,
  input logic              rst_n,
  minhash_sig_unit_if.slave bus
);
  localparam int SHINGLE_W = SHINGLE_BYTES * DATA_BITS;
  localparam int SIG_W     = NUM_HASHES * HASH_BITS;
  localparam int CNT_W     = $clog2(MAX_SHINGLES + 1);

  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(MAX_SHINGLES);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [HASH_BITS-1:0] HASH_MAX = {HASH_BITS{1'b1}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Affine hash k: (A_k * x + B_k) mod 2^HASH_BITS, A_k = 0x9E37 + 2k, B_k = k * 0x1234.
  function automatic logic [HASH_BITS-1:0] affine_hash(input int k, input logic [HASH_BITS-1:0] x);
    logic [31:0]            a_full;
    logic [31:0]            b_full;
    logic [HASH_BITS-1:0]   a_trunc;
    logic [HASH_BITS-1:0]   b_trunc;
    logic [2*HASH_BITS-1:0] prod;
    a_full  = 32'h0000_9E37 + 32'(2 * k);
    b_full  = 32'(k) * 32'h0000_1234;
    a_trunc = HASH_BITS'(a_full);
    b_trunc = HASH_BITS'(b_full);
    prod    = {{HASH_BITS{1'b0}}, a_trunc} * {{HASH_BITS{1'b0}}, x};
    return prod[HASH_BITS-1:0] + b_trunc;
  endfunction

  state_t               state_r;
  state_t               state_n;

  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [SIG_W-1:0]     out_sig_r;
  logic [CNT_W-1:0]     out_count_r;

  logic                 s1_valid_r;
  logic                 s1_last_r;
  logic [HASH_BITS-1:0] s1_hash_r [NUM_HASHES];

  logic [HASH_BITS-1:0] min_r     [NUM_HASHES];
  logic [CNT_W-1:0]     cnt_r;

  logic                 accept_s;
  logic [HASH_BITS-1:0] x_s;
  logic [HASH_BITS-1:0] hash_s    [NUM_HASHES];
  logic [HASH_BITS-1:0] merge_s   [NUM_HASHES];
  logic [CNT_W-1:0]     cnt_inc_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sig   = out_sig_r;
  assign bus.out_count = out_count_r;

  // in_ready is only ever high in ACCUM, so no shingle can land during DRAIN or HOLD.
  assign accept_s = bus.in_valid & in_ready_r;
  assign x_s      = HASH_BITS'(bus.in_shingle);

  // Hash the incoming shingle and merge the stage-1 hashes into the running minimums.
  always_comb begin
    for (int k = 0; k < NUM_HASHES; k++) begin
      hash_s[k]  = affine_hash(k, x_s);
      merge_s[k] = (s1_hash_r[k] < min_r[k]) ? s1_hash_r[k] : min_r[k];
    end
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state: the last shingle is drained through stage 1, then the signature is held.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ACCUM: begin
        if (accept_s && bus.in_last) begin
          state_n = DRAIN;
        end else begin
          state_n = ACCUM;
        end
      end
      DRAIN: begin
        state_n = HOLD;
      end
      HOLD: begin
        if (out_valid_r && bus.out_ready) begin
          state_n = ACCUM;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = ACCUM;
      end
    endcase
  end

  // Handshake flags registered straight from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_n == ACCUM);
      out_valid_r <= (state_n == HOLD);
    end
  end

  // Stage 1: capture the hashes and last flag of the accepted shingle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      for (int k = 0; k < NUM_HASHES; k++) begin
        s1_hash_r[k] <= {HASH_BITS{1'b0}};
      end
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_last_r <= bus.in_last;
        for (int k = 0; k < NUM_HASHES; k++) begin
          s1_hash_r[k] <= hash_s[k];
        end
      end
    end
  end

  // Running minimums and shingle counter; on the block's last shingle the merged
  // result is published and the accumulators restart for the next block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      out_sig_r   <= {SIG_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      for (int k = 0; k < NUM_HASHES; k++) begin
        min_r[k] <= HASH_MAX;
      end
    end else if (s1_valid_r) begin
      if (s1_last_r) begin
        cnt_r       <= {CNT_W{1'b0}};
        out_count_r <= cnt_inc_s;
        for (int k = 0; k < NUM_HASHES; k++) begin
          min_r[k]                          <= HASH_MAX;
          out_sig_r[k*HASH_BITS +: HASH_BITS] <= merge_s[k];
        end
      end else begin
        cnt_r <= cnt_inc_s;
        for (int k = 0; k < NUM_HASHES; k++) begin
          min_r[k] <= merge_s[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_minhash_sig_unit.sv
// Directed self-checking bench for minhash_sig_unit with hand-computed signatures.
module tb_minhash_sig_unit;
  logic clk;
  logic rst_n;

  int checks;
  int passed;

  // Hand-computed signatures {w3,w2,w1,w0}.
  localparam logic [63:0] SIG_X0  = 64'h369C_2468_1234_0000; // x = 0x0000
  localparam logic [63:0] SIG_X1  = 64'hD4D9_C2A3_B06D_9E37; // x = 0x0001
  localparam logic [63:0] SIG_X12 = 64'h7316_60DE_4EA6_3C6E; // min over x = 0x0001, 0x0002
  localparam logic [63:0] SIG_X2  = 64'h7316_60DE_4EA6_3C6E; // x = 0x0002 alone

  minhash_sig_unit_if bus ();

  minhash_sig_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One accepted shingle; in_ready must be high going into the accepting edge.
  task automatic send(input logic [15:0] x, input logic last);
    check("send_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid   = 1'b1;
    bus.in_shingle = x;
    bus.in_last    = last;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
  endtask

  // Block end: checks the 2-cycle latency, then the signature and count.
  task automatic expect_sig(input string tag, input logic [63:0] sig, input logic [6:0] cnt);
    check({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_drain_ready"}, 64'(bus.in_ready), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_sig"}, 64'(bus.out_sig), sig);
    check({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_hs_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_hs_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    checks         = 0;
    passed         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_shingle = 16'h0000;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset values.
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sig", 64'(bus.out_sig), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);

    // 1: single-shingle block of 0x0000.
    send(16'h0000, 1'b1);
    expect_sig("t1", SIG_X0, 7'd1);
    handshake("t1");

    // 2: back-to-back 0x0001 then 0x0000 (last).
    send(16'h0001, 1'b0);
    send(16'h0000, 1'b1);
    expect_sig("t2", SIG_X0, 7'd2);
    handshake("t2");

    // Gaps: shingle 0x0000 presented with in_valid=0 must not lower the mins.
    send(16'h0001, 1'b0);
    bus.in_shingle = 16'h0000;
    bus.in_last    = 1'b1;
    tick();
    tick();
    tick();
    bus.in_last    = 1'b0;
    check("gap_out_valid", 64'(bus.out_valid), 64'd0);
    send(16'h0002, 1'b1);
    expect_sig("gap", SIG_X12, 7'd2);
    handshake("gap");

    // 3: held signature with out_ready low; in_valid junk must be ignored.
    send(16'h0002, 1'b1);
    expect_sig("t3", SIG_X2, 7'd1);
    bus.in_valid   = 1'b1;
    bus.in_shingle = 16'h0000;
    bus.in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t3_hold_sig", 64'(bus.out_sig), SIG_X2);
      check("t3_hold_count", 64'(bus.out_count), 64'd1);
      check("t3_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    handshake("t3");
    tick();
    check("t3_no_stray_accept", 64'(bus.out_valid), 64'd0);

    // 4: consecutive blocks {0x0001} and {0x0000}; no carry-over of mins.
    send(16'h0001, 1'b1);
    expect_sig("t4a", SIG_X1, 7'd1);
    handshake("t4a");
    send(16'h0000, 1'b1);
    expect_sig("t4b", SIG_X0, 7'd1);
    handshake("t4b");

    // 5: 70 non-last 0x0001 then last 0x0001 -> count saturates at 64.
    for (int i = 0; i < 70; i++) begin
      send(16'h0001, 1'b0);
    end
    send(16'h0001, 1'b1);
    expect_sig("t5", SIG_X1, 7'd64);
    handshake("t5");

    // 6: reset while holding a signature discards it.
    send(16'h0002, 1'b1);
    expect_sig("t6_pre", SIG_X2, 7'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_ready", 64'(bus.in_ready), 64'd1);
    check("t6_rst_sig", 64'(bus.out_sig), 64'd0);
    check("t6_rst_count", 64'(bus.out_count), 64'd0);
    send(16'h0000, 1'b1);
    expect_sig("t6", SIG_X0, 7'd1);
    handshake("t6");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
